alu_job_sequencer: RTL and testbench
====================================

// Module: alu_job_sequencer
// PURPOSE
//  Job scheduler in front of the 8-bit ALU/tournament datapath: replaces the free-running PC/ROM opcode source.
//  Accepts one {opcode,a,b} job at a time over valid/ready and drives registered ctrl/a/b into the ALU mux.
//  Issues one-cycle clear pulses to the sequential tournament units (PesoLigero/Pesado/Mixto) and waits out their accumulation.
//  Captures s and flags into a held response until the consumer takes it.
// PARAMETERS
//  W            8   operand/result width
//  FW           12  ALU flags width
//  TOUR_CYCLES  4   accumulate cycles for ops 13..15 after clear; legal range 1..15
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   synchronous, active-low
//  req_valid  in   1   job offered
//  req_ready  out  1   sequencer can accept; high only in IDLE with reset=1
//  req_op     in   4   ALU opcode: 0 add,1 sub,2 mul,3 div,4 not,5 or,6 and,7 xor,8 lsl,9 lsr,10 asr,11 rol,12 ror,13 pl,14 pp,15 pm
//  req_a      in   W   operand a
//  req_b      in   W   operand b
//  alu_ctrl   out  4   registered opcode to ALU mux
//  alu_a      out  W   registered operand a to ALU
//  alu_b      out  W   registered operand b to ALU
//  tour_clr   out  3   one-hot clear, active-high: bit0 pl, bit1 pp, bit2 pm
//  alu_s      in   W   ALU result
//  alu_flags  in   FW  ALU flags
//  res_valid  out  1   response held
//  res_ready  in   1   consumer takes response
//  res_data   out  W   captured result
//  res_flags  out  FW  captured flags
//  res_op     out  4   opcode of captured job
//  job_count  out  8   completed jobs, wraps 255->0
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE; alu_ctrl, alu_a, alu_b, tour_clr, res_* and job_count all 0.
//   req_ready=0 while reset=0.
//  FSM states: IDLE, EXEC, CLEAR, ACCUM, RESP.
//  IDLE: req_ready=1. On req_valid&req_ready, latch op/a/b into alu_ctrl/alu_a/alu_b (visible next cycle).
//   Then go to CLEAR if op>=13, else EXEC.
//  EXEC (1 cycle): ALU settles. At end of cycle, capture alu_s/alu_flags/alu_ctrl into res_*. Go to RESP.
//  CLEAR (1 cycle): tour_clr bit (op-13) = 1, other bits 0. Load down-counter with TOUR_CYCLES. Go to ACCUM.
//  ACCUM: tour_clr=0; decrement each cycle. On the cycle counter==1: capture into res_* and go to RESP.
//  RESP: res_valid=1. res_* and alu_* are held stable. req_ready=0; req_valid is ignored.
//   On res_valid&res_ready: job_count+1 (mod 256), go to IDLE. res_valid=0 next cycle.
//   res_data/res_flags keep their last value.
//  Latency from acceptance edge to res_valid high:
//   combinational ops (0..12): 2 cycles
//   tournament ops (13..15): 2+TOUR_CYCLES cycles
//  No back-to-back: minimum 1 IDLE cycle between jobs.
//  alu_* change only on acceptance. Inputs other than in IDLE and at capture are don't-care.
//  Flags are copied unmodified, e.g. divide-by-zero E. No arithmetic inside the block.
//  Reset mid-job: job aborted; no res_valid, no job_count increment, tour_clr forced 0. IDLE after reset=1.
//  res_ready high with res_valid low: no effect.
// TESTING
//  T1 reset, then op0 a=7F b=06 with ALU model: res_valid at accept+2, res_data=85, res_op=0, job_count=1 after take.
//  T2 op1 a=FF b=01, res_ready low 5 cycles: res_valid/res_data=FE stable, req_ready=0; second offered job not accepted.
//  T3 op13 a=11 b=04, TOUR_CYCLES=4: tour_clr=001 exactly one cycle at accept+1; res_valid at accept+6.
//   Repeat op15: tour_clr=100.
//  T4 op14, reset low one cycle during ACCUM: res_valid never rises, all outputs 0, job_count unchanged.
//   req_ready=1 the cycle after reset returns high.
//  T5 op3 b=00 with ALU E=1: res_flags equals alu_flags sampled at capture, including the E bit.
//  T6 256 consecutive op6 jobs with res_ready tied 1: job_count returns to 00. Each res_valid pulse is exactly 1 cycle.

Source files
------------

// File: rtl/alu_job_sequencer.sv
// alu_job_sequencer: one-at-a-time ALU job scheduler with tournament clear/accumulate wait and held response
module alu_job_sequencer #(
  parameter int W = 8,
  parameter int FW = 12,
  parameter int TOUR_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [W-1:0]  req_a,
  input  logic [W-1:0]  req_b,
  output logic [3:0]    alu_ctrl,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [2:0]    tour_clr,
  input  logic [W-1:0]  alu_s,
  input  logic [FW-1:0] alu_flags,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_data,
  output logic [FW-1:0] res_flags,
  output logic [3:0]    res_op,
  output logic [7:0]    job_count
);
  typedef enum logic [2:0] {IDLE, EXEC, CLEAR, ACCUM, RESP} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic cap;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE  ? (req_valid ? (req_op >= 4'd13 ? CLEAR : EXEC) : IDLE) :
                state == EXEC  ? RESP :
                state == CLEAR ? ACCUM :
                state == ACCUM ? (cnt == 4'd1 ? RESP : ACCUM) :
                res_ready      ? IDLE : RESP;
  always_comb begin
    req_ready = state == IDLE && reset;
    res_valid = state == RESP;
    tour_clr  = state == CLEAR ? {alu_ctrl == 4'd15, alu_ctrl == 4'd14, alu_ctrl == 4'd13} : 3'b000;
  end
  // capture on the single EXEC cycle, or on the last accumulate cycle of a tournament op
  assign cap = state == EXEC || (state == ACCUM && cnt == 4'd1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_ctrl  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      res_data  <= '0;
      res_flags <= '0;
      res_op    <= '0;
      job_count <= '0;
      cnt       <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        alu_ctrl <= req_op;
        alu_a    <= req_a;
        alu_b    <= req_b;
      end
      if (cap) begin
        res_data  <= alu_s;
        res_flags <= alu_flags;
        res_op    <= alu_ctrl;
      end
      cnt <= state == CLEAR ? 4'(TOUR_CYCLES) : cnt - 4'd1;
      if (res_valid && res_ready) job_count <= job_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_alu_job_sequencer.sv
// tb_alu_job_sequencer: random and directed jobs through the sequencer against a scoreboard and ALU/tournament model
module tb_alu_job_sequencer;
  localparam int TC = 4;
  logic clk = 0, reset = 0, req_valid = 0, req_ready, res_valid, res_ready = 1;
  logic [3:0] req_op = 0, alu_ctrl, res_op;
  logic [7:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_s, res_data, job_count;
  logic [11:0] alu_flags, res_flags;
  logic [2:0] tour_clr;
  logic [7:0] acc [3];
  int cyc = 0, compared = 0, mismatched = 0, exp_jobs = 0;
  logic rr_rand = 0, prev_v = 0, prev_take = 0;
  typedef struct {logic [3:0] op; logic [7:0] a, b, s; logic [11:0] f; int cyc;} job_t;
  job_t q[$];

  alu_job_sequencer #(.W(8), .FW(12), .TOUR_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
    .tour_clr(tour_clr), .alu_s(alu_s), .alu_flags(alu_flags), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_flags(res_flags), .res_op(res_op),
    .job_count(job_count));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU model: flags = {E, 3'b0, op, Z, 3'b0}; tournament units fold in their accumulation count
  function automatic logic [19:0] alu_ref(input logic [3:0] op, input logic [7:0] a, b, k);
    logic [7:0] s;
    logic [7:0] sa;
    sa = $signed(a) >>> b[2:0];
    case (op)
      0: s = a + b;
      1: s = a - b;
      2: s = a * b;
      3: s = b == 0 ? 8'hFF : a / b;
      4: s = ~a;
      5: s = a | b;
      6: s = a & b;
      7: s = a ^ b;
      8: s = a << b[2:0];
      9: s = a >> b[2:0];
      10: s = sa;
      11: s = (a << b[2:0]) | (a >> (4'd8 - {1'b0, b[2:0]}));
      12: s = (a >> b[2:0]) | (a << (4'd8 - {1'b0, b[2:0]}));
      13: s = a + k * b;
      14: s = a - k;
      default: s = (a ^ b) + k;
    endcase
    return {op == 3 && b == 0, 3'b0, op, s == 0, 3'b0, s};
  endfunction

  // each tournament unit restarts its accumulation on its own clear bit
  initial for (int i = 0; i < 3; i++) acc[i] = 8'h40;
  always @(posedge clk)
    for (int i = 0; i < 3; i++) acc[i] <= tour_clr[i] ? 8'h00 : acc[i] + 8'h01;
  always_comb
    {alu_flags, alu_s} = alu_ref(alu_ctrl, alu_a, alu_b,
      alu_ctrl == 13 ? acc[0] : alu_ctrl == 14 ? acc[1] : alu_ctrl == 15 ? acc[2] : 8'h00);

  always @(posedge clk) if (rr_rand) #1 res_ready = 1'($urandom_range(0, 1));

  task automatic check(input string name, input logic [31:0] act, exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: compares held responses, latency, clear pulses, operand registers and job count
  always @(negedge clk) begin
    if (!reset) begin
      prev_v = 0;
      prev_take = 0;
    end else begin
      if (q.size() != 0 && cyc > q[0].cyc) begin
        check("alu_ctrl", 32'(alu_ctrl), 32'(q[0].op));
        check("alu_ab", {16'h0, alu_a, alu_b}, {16'h0, q[0].a, q[0].b});
      end
      check("tour_clr", 32'(tour_clr),
        (q.size() != 0 && q[0].op >= 13 && cyc == q[0].cyc + 1) ? 32'(1 << (q[0].op - 13)) : 0);
      check("job_count", 32'(job_count), 32'(exp_jobs[7:0]));
      if (prev_take) check("res_valid_pulse", 32'(res_valid), 0);
      if (res_valid) begin
        if (q.size() == 0) begin
          check("unexpected_res_valid", 1, 0);
        end else begin
          if (!prev_v) check("latency", cyc - q[0].cyc, q[0].op >= 13 ? 2 + TC : 2);
          check("res_data", 32'(res_data), 32'(q[0].s));
          check("res_flags", 32'(res_flags), 32'(q[0].f));
          check("res_op", 32'(res_op), 32'(q[0].op));
          check("req_ready_in_resp", 32'(req_ready), 0);
          if (res_ready) begin
            void'(q.pop_front());
            exp_jobs++;
          end
        end
      end
      prev_v = res_valid;
      prev_take = res_valid && res_ready;
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] a, b);
    job_t j;
    int n = 0;
    @(posedge clk) #1;
    req_valid = 1;
    req_op = op;
    req_a = a;
    req_b = b;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      j.op = op;
      j.a = a;
      j.b = b;
      {j.f, j.s} = alu_ref(op, a, b, 8'(TC - 1));
      j.cyc = cyc;
      q.push_back(j);
    end
    @(posedge clk) #1;
    req_valid = 0;
    req_op = 4'($urandom);
    req_a = 8'($urandom);
    req_b = 8'($urandom);
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("response_timeout", 0, 1);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk) #1 reset = 0;
    @(posedge clk) #1;
    q.delete();
    exp_jobs = 0;
    reset = 1;
    @(negedge clk);
    check("reset_outputs", {alu_ctrl, alu_a, alu_b, tour_clr, res_valid, res_op},
      {4'h0, 8'h0, 8'h0, 3'b0, 1'b0, 4'h0});
    check("reset_res", {res_flags, res_data, job_count}, 0);
    check("req_ready_after_reset", 32'(req_ready), 1);
  endtask

  initial begin
    do_reset();
    // reset during accumulation aborts the job
    issue(14, 8'h33, 8'h05);
    repeat (2) @(posedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    issue(0, 8'h7F, 8'h06);
    wait_empty();
    // held response while consumer stalls; a second offer must be ignored
    res_ready = 0;
    issue(1, 8'hFF, 8'h01);
    for (int n = 0; n < 20 && !res_valid; n++) @(negedge clk);
    check("t2_res_valid", 32'(res_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk) #1;
      req_valid = 1;
      req_op = 2;
      req_a = 8'h55;
      @(negedge clk);
      check("t2_req_ready", 32'(req_ready), 0);
      check("t2_hold", {alu_ctrl, alu_a, res_data}, {4'h1, 8'hFF, 8'hFE});
    end
    @(posedge clk) #1;
    req_valid = 0;
    res_ready = 1;
    wait_empty();
    issue(13, 8'h11, 8'h04);
    wait_empty();
    issue(15, 8'h22, 8'h09);
    wait_empty();
    issue(3, 8'h9A, 8'h00);
    wait_empty();
    rr_rand = 1;
    for (int i = 0; i < 150; i++)
      issue(4'($urandom), 8'($urandom), $urandom_range(0, 7) == 0 ? 8'h00 : 8'($urandom));
    wait_empty();
    rr_rand = 0;
    #2 res_ready = 1;
    do_reset();
    for (int i = 0; i < 256; i++) issue(6, 8'($urandom), 8'($urandom));
    wait_empty();
    @(negedge clk);
    check("t6_job_count_wrap", 32'(job_count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
